// File: rtl/axi_xadc_sample_slave.sv
// AXI4 read-only slave exposing a circular buffer of XADC samples.
// Samples are written by a capture strobe; INCR/FIXED bursts read them back over AR/R.
module axi_xadc_sample_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int BUF_DEPTH_LOG2     = 10,
    parameter int SAMPLE_WIDTH       = 12
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]       sample_data,
    output logic [BUF_DEPTH_LOG2-1:0]     wr_ptr,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
    localparam logic [BUF_DEPTH_LOG2-1:0] IDX_ONE = 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]                    state;
    logic [SAMPLE_WIDTH-1:0]       mem [DEPTH];
    logic [SAMPLE_WIDTH-1:0]       ram_q;
    logic [BUF_DEPTH_LOG2-1:0]     rd_idx;
    logic [7:0]                    burst_len;
    logic [7:0]                    issue_cnt;
    logic                          burst_fixed;
    logic                          burst_err;
    logic                          issue_done;
    logic                          fetch_valid;
    logic                          fetch_last;
    logic                          skid_valid;
    logic                          skid_last;
    logic [C_S_AXI_DATA_WIDTH-1:0] skid_data;
    logic [C_S_AXI_DATA_WIDTH-1:0] land_data;
    logic [1:0]                    occ_after_pop;
    logic                          ar_hs;
    logic                          r_pop;
    logic                          issue;
    logic                          unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:BUF_DEPTH_LOG2+2],
                                S_AXI_ARADDR[1:0]};

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_pop = S_AXI_RVALID && S_AXI_RREADY;

    // A fetch may only be issued if, once it lands next cycle, the output or skid register is free.
    assign occ_after_pop = {1'b0, S_AXI_RVALID} + {1'b0, skid_valid} + {1'b0, fetch_valid}
                         - {1'b0, r_pop};
    assign issue = (state == ST_BURST) && !issue_done && (occ_after_pop <= 2'd1);

    assign land_data   = burst_err ? '0 : {{(C_S_AXI_DATA_WIDTH-SAMPLE_WIDTH){1'b0}}, ram_q};
    assign S_AXI_RRESP = burst_err ? 2'b10 : 2'b00;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
        end else if (sample_valid) begin
            wr_ptr <= wr_ptr + IDX_ONE;
        end
    end

    // Buffer RAM is never reset; nonblocking read gives read-first on same-index collisions.
    always_ff @(posedge ACLK) begin
        if (sample_valid) begin
            mem[wr_ptr] <= sample_data;
        end
        if (issue) begin
            ram_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RID     <= '0;
            rd_idx        <= '0;
            burst_len     <= '0;
            burst_fixed   <= 1'b0;
            burst_err     <= 1'b0;
            issue_cnt     <= '0;
            issue_done    <= 1'b0;
            fetch_valid   <= 1'b0;
            fetch_last    <= 1'b0;
        end else begin
            fetch_valid <= issue;
            if (issue) begin
                fetch_last <= (issue_cnt == burst_len);
            end
            case (state)
                ST_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_hs) begin
                        S_AXI_ARREADY <= 1'b0;
                        state         <= ST_BURST;
                        S_AXI_RID     <= S_AXI_ARID;
                        rd_idx        <= S_AXI_ARADDR[BUF_DEPTH_LOG2+1:2];
                        burst_len     <= S_AXI_ARLEN;
                        burst_fixed   <= (S_AXI_ARBURST == 2'b00);
                        burst_err     <= S_AXI_ARBURST[1] || (S_AXI_ARSIZE != 3'b010);
                        issue_cnt     <= '0;
                        issue_done    <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 8'd1;
                        if (issue_cnt == burst_len) begin
                            issue_done <= 1'b1;
                        end
                        if (!burst_fixed) begin
                            rd_idx <= rd_idx + IDX_ONE;
                        end
                    end
                    if (r_pop && S_AXI_RLAST) begin
                        state         <= ST_IDLE;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register backed by a one-entry skid so a stalled master never loses a landed fetch.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RLAST  <= 1'b0;
            S_AXI_RDATA  <= '0;
            skid_valid   <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
        end else if (!S_AXI_RVALID || r_pop) begin
            if (skid_valid) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= skid_data;
                S_AXI_RLAST  <= skid_last;
                skid_valid   <= fetch_valid;
                skid_data    <= land_data;
                skid_last    <= fetch_last;
            end else if (fetch_valid) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= land_data;
                S_AXI_RLAST  <= fetch_last;
            end else begin
                S_AXI_RVALID <= 1'b0;
                S_AXI_RLAST  <= 1'b0;
            end
        end else if (fetch_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= land_data;
            skid_last  <= fetch_last;
        end
    end

endmodule

// File: tb/tb_axi_xadc_sample_slave.sv
// Directed self-checking bench for axi_xadc_sample_slave.
// Expected read data comes from the sample values the bench itself wrote.
module tb_axi_xadc_sample_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic [9:0]  wr_ptr;
    logic [0:0]  S_AXI_ARID = '0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_ARSIZE = 3'b010;
    logic [1:0]  S_AXI_ARBURST = 2'b01;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    axi_xadc_sample_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .wr_ptr        (wr_ptr),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total_cnt = 0;
    int pass_cnt = 0;

    int          nbeats;
    logic [31:0] beat_data [256];
    logic        beat_last [256];
    logic [1:0]  beat_resp [256];
    logic [0:0]  beat_id [256];
    int          beat_cyc [256];
    int          first_valid;
    int          stall_err;
    int          arready_err;
    bit          burst_done;
    logic        arready_after;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Hold sample_valid for count consecutive cycles; data is (first + i) masked.
    task automatic write_samples(input logic [11:0] first, input int count, input logic [11:0] mask);
        for (int i = 0; i < count; i++) begin
            sample_valid = 1'b1;
            sample_data  = (first + 12'(i)) & mask;
            @(posedge ACLK); #1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [0:0] id);
        int n;
        n = 0;
        while (!S_AXI_ARREADY && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("ar_ready_wait", 64'(n < 50), 64'd1);
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARBURST = burst;
        S_AXI_ARSIZE  = size;
        S_AXI_ARID    = id;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    // Collect R beats; cycle k=0 is just after the AR handshake edge.
    task automatic collect_burst(input bit rand_ready);
        bit          prev_stall;
        logic [31:0] p_data;
        logic        p_last;
        logic [1:0]  p_resp;
        logic [0:0]  p_id;
        nbeats = 0; first_valid = -1; stall_err = 0; arready_err = 0;
        burst_done = 1'b0; prev_stall = 1'b0;
        p_data = '0; p_last = 1'b0; p_resp = '0; p_id = '0;
        for (int k = 0; k < 400; k++) begin
            if (S_AXI_ARREADY) arready_err++;
            if (S_AXI_RVALID && first_valid < 0) first_valid = k;
            if (prev_stall && (!S_AXI_RVALID || S_AXI_RDATA !== p_data || S_AXI_RLAST !== p_last ||
                               S_AXI_RRESP !== p_resp || S_AXI_RID !== p_id))
                stall_err++;
            S_AXI_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (S_AXI_RVALID && S_AXI_RREADY && nbeats < 256) begin
                beat_data[nbeats] = S_AXI_RDATA;
                beat_last[nbeats] = S_AXI_RLAST;
                beat_resp[nbeats] = S_AXI_RRESP;
                beat_id[nbeats]   = S_AXI_RID;
                beat_cyc[nbeats]  = k;
                nbeats++;
                burst_done = S_AXI_RLAST;
            end
            prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
            p_data = S_AXI_RDATA; p_last = S_AXI_RLAST; p_resp = S_AXI_RRESP; p_id = S_AXI_RID;
            @(posedge ACLK); #1;
            if (burst_done) break;
        end
        S_AXI_RREADY  = 1'b0;
        arready_after = S_AXI_ARREADY;
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [0:0] id, input bit rand_ready);
        send_ar(addr, len, burst, size, id);
        collect_burst(rand_ready);
    endtask

    // Each beat packs {resp, last, id, data} against exp_q; RLAST expected only on the final beat.
    task automatic verify_burst(input string tag, input logic [0:0] exp_id, input logic [1:0] exp_resp);
        int n;
        n = exp_q.size();
        check({tag, "_done"}, 64'(burst_done), 64'd1);
        check({tag, "_nbeats"}, 64'(nbeats), 64'(n));
        for (int i = 0; i < n && i < nbeats; i++)
            check($sformatf("%s_beat%0d", tag, i),
                  {28'd0, beat_resp[i], beat_last[i], beat_id[i], beat_data[i]},
                  {28'd0, exp_resp, (i == n - 1) ? 1'b1 : 1'b0, exp_id, exp_q[i]});
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
        check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
        check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        check("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
        check("rst_rresp_rid", 64'({S_AXI_RRESP, S_AXI_RID}), 64'd0);
        check("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("arready_after_rst", 64'(S_AXI_ARREADY), 64'd1);

        // Basic INCR burst with latency and back-to-back beats
        write_samples(12'h000, 16, 12'hFFF);
        check("t1_wr_ptr", 64'(wr_ptr), 64'd16);
        exp_q = '{32'h0, 32'h1, 32'h2, 32'h3};
        run_burst(32'h0, 8'd3, 2'b01, 3'b010, 1'b1, 1'b0);
        verify_burst("t1", 1'b1, 2'b00);
        check("t1_first_valid", 64'(first_valid), 64'd2);
        check("t1_last_cyc", 64'(beat_cyc[3]), 64'd5);
        check("t1_arready_busy", 64'(arready_err), 64'd0);
        check("t1_arready_after", 64'(arready_after), 64'd1);
        check("t1_rvalid_after", 64'(S_AXI_RVALID), 64'd0);

        // Fill whole buffer with its index, then read across the wrap point
        write_samples(12'h010, 1024, 12'h3FF);
        check("t2_wr_ptr", 64'(wr_ptr), 64'd16);
        exp_q = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
        run_burst(32'hFF8, 8'd3, 2'b01, 3'b010, 1'b0, 1'b0);
        verify_burst("t2", 1'b0, 2'b00);

        // FIXED, aliased/unaligned address, error bursts, then a clean burst
        exp_q = '{32'h4, 32'h4, 32'h4};
        run_burst(32'h10, 8'd2, 2'b00, 3'b010, 1'b1, 1'b0);
        verify_burst("t3_fixed", 1'b1, 2'b00);
        exp_q = '{32'h5};
        run_burst(32'h8000_0017, 8'd0, 2'b01, 3'b010, 1'b0, 1'b0);
        verify_burst("t3_alias", 1'b0, 2'b00);
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0};
        run_burst(32'h10, 8'd3, 2'b10, 3'b010, 1'b1, 1'b0);
        verify_burst("t3_wrap_err", 1'b1, 2'b10);
        exp_q = '{32'h0};
        run_burst(32'h10, 8'd0, 2'b01, 3'b001, 1'b0, 1'b0);
        verify_burst("t3_size_err", 1'b0, 2'b10);
        exp_q = '{32'h2, 32'h3};
        run_burst(32'h8, 8'd1, 2'b01, 3'b010, 1'b1, 1'b0);
        verify_burst("t3_okay", 1'b1, 2'b00);

        // Random RREADY backpressure on a 16-beat burst
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(16 + i));
        run_burst(32'h40, 8'd15, 2'b01, 3'b010, 1'b1, 1'b1);
        verify_burst("t4", 1'b1, 2'b00);
        check("t4_stall_stable", 64'(stall_err), 64'd0);
        check("t4_arready_busy", 64'(arready_err), 64'd0);
        check("t4_arready_after", 64'(arready_after), 64'd1);

        // Reset during beat 3 of an 8-beat burst
        send_ar(32'h0, 8'd7, 2'b01, 3'b010, 1'b1);
        S_AXI_RREADY = 1'b1;
        repeat (4) begin
            @(posedge ACLK); #1;
        end
        check("t5_beat3_valid", 64'({S_AXI_RVALID, S_AXI_RDATA}), 64'h1_0000_0002);
        ARESET = 1'b1;
        #1;
        check("t5_rvalid_async", 64'(S_AXI_RVALID), 64'd0);
        check("t5_wr_ptr_rst", 64'(wr_ptr), 64'd0);
        check("t5_rlast_rst", 64'(S_AXI_RLAST), 64'd0);
        S_AXI_RREADY = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("t5_arready_in_rst", 64'(S_AXI_ARREADY), 64'd0);
        @(posedge ACLK); #1;
        check("t5_arready_rel", 64'(S_AXI_ARREADY), 64'd1);
        exp_q = '{32'h1};
        run_burst(32'h4, 8'd0, 2'b01, 3'b010, 1'b1, 1'b0);
        verify_burst("t5_single", 1'b1, 2'b00);

        // 1025 strobes wrap wr_ptr to 1 and overwrite index 0
        write_samples(12'h100, 1025, 12'hFFF);
        check("t6_wr_ptr", 64'(wr_ptr), 64'd1);
        exp_q = '{32'h500, 32'h101};
        run_burst(32'h0, 8'd1, 2'b01, 3'b010, 1'b0, 1'b0);
        verify_burst("t6", 1'b0, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_xadc_sample_slave.md
Name: axi_xadc_sample_slave

Overview:
AXI4 read-only slave (responder) that exposes a circular buffer of XADC samples to an AXI master such as the XADC read master.
- Write side: fed by a sample strobe from the XADC capture logic.
- Read side: serves INCR/FIXED read bursts over AR/R channels.
- Sits between XADC capture and the interconnect; no AW/W/B channels exist on this block.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of ARID/RID
C_S_AXI_ADDR_WIDTH, 32, width of ARADDR
C_S_AXI_DATA_WIDTH, 32, width of RDATA (fixed 32)
BUF_DEPTH_LOG2, 10, log2 of buffer depth in samples (1024 words)
SAMPLE_WIDTH, 12, width of an XADC sample

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
sample_valid  in  1  one-cycle strobe, writes sample_data into buffer
sample_data  in  SAMPLE_WIDTH  XADC conversion result
wr_ptr  out  BUF_DEPTH_LOG2  next buffer index to be written
S_AXI_ARID  in  C_S_AXI_ID_WIDTH  read ID
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  byte address
S_AXI_ARLEN  in  8  beats minus one
S_AXI_ARSIZE  in  3  beat size
S_AXI_ARBURST  in  2  burst type
S_AXI_ARVALID  in  1  address valid
S_AXI_ARREADY  out  1  address ready
S_AXI_RID  out  C_S_AXI_ID_WIDTH  echoed ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  response
S_AXI_RLAST  out  1  last beat
S_AXI_RVALID  out  1  data valid
S_AXI_RREADY  in  1  data ready

Behaviour:
Reset values:
- wr_ptr=0, ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0; FSM=IDLE.
- ARREADY rises the first cycle after ARESET deasserts.
- Reset mid-burst aborts the burst immediately (RVALID low asynchronously); no resumption.
- Buffer RAM is not reset.

Sample write:
- On sample_valid, RAM[wr_ptr] <= sample_data and wr_ptr <= wr_ptr+1.
- wr_ptr wraps from 2^BUF_DEPTH_LOG2-1 to 0; no full/overrun flag, oldest data overwritten.

Addressing:
- Word index = ARADDR[BUF_DEPTH_LOG2+1:2].
- ARADDR[1:0] ignored (aligned down).
- Upper address bits ignored (buffer aliases).

Read FSM:
- IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ID, index, ARLEN, type, and error flag; go to BURST. ARREADY=0 in all other states (one outstanding burst).
- BURST: RAM read has 1-cycle registered latency, so first RVALID asserts 2 cycles after the AR handshake.
- Throughput: one beat per cycle while RREADY is held high (prefetch/skid register required).
- Beat counter counts 0..ARLEN; RLAST=1 only on beat ARLEN.
- After the RLAST handshake, return to IDLE (ARREADY=1 the next cycle).

Burst types:
- INCR (01): index+1 per beat, wrapping modulo buffer depth.
- FIXED (00): same index every beat.
- WRAP (10), reserved (11), or ARSIZE!=3'b010: error burst. All ARLEN+1 beats return RRESP=2'b10 (SLVERR) and RDATA=0.
- Otherwise RRESP=2'b00.

R channel rules:
- RDATA = zero-extended sample in bits [SAMPLE_WIDTH-1:0].
- RID = latched ARID.
- While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST/RID hold stable.
- RVALID never drops without a handshake, except on reset.

Collisions:
- Sample write and burst read of the same index in the same cycle: read returns old data (read-first).
- A sample written at an index before its RAM fetch is returned in that burst.

Test Plan:
1. Write samples 0x000..0x00F (wr_ptr->16); AR ADDR=0x0, LEN=3, INCR, SIZE=2, ID=1, RREADY=1 -> RDATA 0,1,2,3, RLAST on beat 4, RRESP=00, RID=1; first RVALID 2 cycles after AR handshake; beats on consecutive cycles.
2. Fill all 1024 words with data=index[11:0]; AR ADDR=0xFF8, LEN=3, INCR -> RDATA 0x3FE, 0x3FF, 0x000, 0x001 (index wrap).
3. AR ADDR=0x10, LEN=2, FIXED -> RDATA 0x004 three times; ARBURST=2'b10, LEN=3 -> 4 beats RRESP=10, RDATA=0, RLAST on 4th; next burst is OKAY.
4. Random RREADY toggling during LEN=15 INCR burst -> RDATA/RLAST stable while stalled; 16 handshakes in index order; ARREADY=0 until after last handshake.
5. Assert ARESET during beat 3 of LEN=7 burst -> RVALID=0 at once, wr_ptr=0; after release, ARREADY=1 and a new LEN=0 burst returns 1 beat with RLAST=1.
6. 1025 sample_valid strobes -> wr_ptr=1, index 0 holds the 1025th sample.
